wmul_share_ctrl: RTL

- Round-robin scheduler that shares one combinational Wallace tree multiplier (built from the team's half/full adder cells) between NUM_REQ requesters.
- Each cycle it accepts at most one operand pair and registers it onto the multiplier inputs.
- On the next edge it captures the product and routes it to the originating requester's one-deep result buffer.
- Sits between the ALU-side requesters and the multiplier datapath.

---
 rtl/wmul_pkg.sv | 9 +
 rtl/wmul_share_ctrl_if.sv | 25 ++
 rtl/wmul_rr_arb.sv | 29 ++
 rtl/wmul_share_ctrl.sv | 80 ++++++++
 4 files changed

// File: rtl/wmul_pkg.sv
// wmul_pkg: shared slot-state enum, default sizes and id-width helper for wmul_share_ctrl
package wmul_pkg;
  typedef enum logic [1:0] {IDLE, INFLIGHT, HOLD} slot_state_t;
  localparam int NUM_REQ_DEF = 4;
  localparam int W_DEF = 8;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wmul_share_ctrl_if.sv
// wmul_share_ctrl_if: requester req/rsp handshakes plus multiplier operand/product bus; slave = controller, master = requesters+multiplier
interface wmul_share_ctrl_if #(
  parameter int NUM_REQ = wmul_pkg::NUM_REQ_DEF,
  parameter int W = wmul_pkg::W_DEF
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic mul_valid;
  logic [2*W-1:0] mul_p;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [NUM_REQ-1:0] rsp_ready;
  logic [NUM_REQ*2*W-1:0] rsp_p;
  modport slave (
    input req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, mul_valid, rsp_valid, rsp_p
  );
  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input req_ready, mul_a, mul_b, mul_valid, rsp_valid, rsp_p
  );
endinterface

// File: rtl/wmul_rr_arb.sv
// wmul_rr_arb: round-robin arbiter; in elig[N], ptr; out one-hot gnt, gnt_id, any (grant present)
module wmul_rr_arb import wmul_pkg::*; #(
  parameter int N = NUM_REQ_DEF,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);
  logic [IW:0] s;
  logic [IW-1:0] j;
  always_comb begin
    gnt_id = '0;
    any = 1'b0;
    s = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (IW + 1)'(k);
      j = s >= (IW + 1)'(N) ? IW'(s - (IW + 1)'(N)) : IW'(s);
      if (elig[j]) begin
        gnt_id = j;
        any = 1'b1;
      end
    end
    gnt = any ? {{(N - 1){1'b0}}, 1'b1} << gnt_id : '0;
  end
endmodule

// File: rtl/wmul_share_ctrl.sv
// wmul_share_ctrl: shares one multiplier among NUM_REQ requesters; ports clk, rst_n, bus (wmul_share_ctrl_if.slave), plus issue_cnt/stall_cnt when WMUL_PERF_CNT_EN
module wmul_share_ctrl import wmul_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int W = W_DEF
) (
  input logic clk,
  input logic rst_n,
  wmul_share_ctrl_if.slave bus
`ifdef WMUL_PERF_CNT_EN
  ,
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt
`endif
);
  localparam int IW = id_w(NUM_REQ);
  localparam int PW = 2 * W;
  slot_state_t st [NUM_REQ];
  slot_state_t st_nx [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_id;
  logic [IW-1:0] issue_id;
  logic any;
  always_comb begin
    elig = '0;
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = rst_n && bus.req_valid[i] && st[i] == IDLE;
      bus.rsp_valid[i] = st[i] == HOLD;
    end
  end
  wmul_rr_arb #(.N(NUM_REQ), .IW(IW)) u_arb (
    .elig   (elig),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );
  assign bus.req_ready = gnt;
  always_comb begin
    st_nx = st;
    for (int i = 0; i < NUM_REQ; i++)
      st_nx[i] = (st[i] == IDLE && gnt[i]) ? INFLIGHT :
                 st[i] == INFLIGHT ? HOLD :
                 (st[i] == HOLD && bus.rsp_ready[i]) ? IDLE : st[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '{default: IDLE};
      rr_ptr <= '0;
      issue_id <= '0;
      bus.mul_a <= '0;
      bus.mul_b <= '0;
      bus.mul_valid <= 1'b0;
      bus.rsp_p <= '0;
    end else begin
      st <= st_nx;
      bus.mul_valid <= any;
      if (any) begin
        rr_ptr <= gnt_id == IW'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
        issue_id <= gnt_id;
        bus.mul_a <= bus.req_a[gnt_id * W +: W];
        bus.mul_b <= bus.req_b[gnt_id * W +: W];
      end
      if (bus.mul_valid) bus.rsp_p[issue_id * PW +: PW] <= bus.mul_p;
    end
  end
`ifdef WMUL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (any && !(&issue_cnt)) issue_cnt <= issue_cnt + 1'b1;
      if ((elig & (elig - 1'b1)) != '0 && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif
endmodule
